reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard_pkg.sv | 14 +
 rtl/reg_pend_counter.sv | 32 +++
 rtl/reg_scoreboard.sv | 68 ++++++
 tb/tb_reg_scoreboard.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: shared pipeline constants for decode and hazard logic
// Provides default register count, register-select width, default counter
// width and a helper giving the saturation value of a counter of a given width.
package reg_scoreboard_pkg;
    localparam int DEF_NUM_REGS = 8;
    localparam int REG_SEL_W    = 3;
    localparam int DEF_CNT_W    = 2;

    typedef logic [REG_SEL_W-1:0] regSel_t;

    function automatic int cntMax(input int w);
        return (1 << w) - 1;
    endfunction
endpackage

// File: rtl/reg_pend_counter.sv
// reg_pend_counter: outstanding-write counter for one architectural register
// Ports: clk, rst (sync, active high); inc, dec_wb, dec_kill apply as a net
// sum each cycle; count is the registered value, nonzero flags count > 0,
// underflow flags (combinationally) that this cycle's net sum would go below 0.
module reg_pend_counter
    import reg_scoreboard_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec_wb,
    input  logic             dec_kill,
    output logic [CNT_W-1:0] count,
    output logic             nonzero,
    output logic             underflow
);
    // Two guard bits: the top one is the sign of the net result, the next
    // one catches an increment past the maximum.
    logic [CNT_W+1:0] sum;

    assign sum = {2'b00, count}
               + {{(CNT_W+1){1'b0}}, inc}
               - {{(CNT_W+1){1'b0}}, dec_wb}
               - {{(CNT_W+1){1'b0}}, dec_kill};
    assign underflow = sum[CNT_W+1];
    assign nonzero = |count;

    always_ff @(posedge clk)
        count <= (rst || underflow) ? '0 : sum[CNT_W] ? '1 : sum[CNT_W-1:0];
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register outstanding-write scoreboard with issue stall
// Ports: clk, rst (sync, active high); issue_* describe the decoding
// instruction (sources rs1/rs2, destination rd, each with a used flag);
// wb_valid/wb_rd retire a write; kill_valid/kill_rd squash a write;
// stall holds decode, pending shows nonzero counters, err is a sticky
// underflow flag cleared only by reset.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    input  logic [REG_SEL_W-1:0] issue_rs1,
    input  logic                 issue_rs1_used,
    input  logic [REG_SEL_W-1:0] issue_rs2,
    input  logic                 issue_rs2_used,
    input  logic [REG_SEL_W-1:0] issue_rd,
    input  logic                 issue_rd_used,
    input  logic                 wb_valid,
    input  logic [REG_SEL_W-1:0] wb_rd,
    input  logic                 kill_valid,
    input  logic [REG_SEL_W-1:0] kill_rd,
    output logic                 stall,
    output logic [NUM_REGS-1:0]  pending,
    output logic                 err
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cntMax(CNT_W));

    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] rs1Hit, rs2Hit, rdHit, wbHit, killHit;
    logic [NUM_REGS-1:0] busy, full, inc, underflow;
    logic                accept;

    for (genvar g = 0; g < NUM_REGS; g++) begin : gReg
        assign rs1Hit[g]  = issue_rs1 == REG_SEL_W'(g);
        assign rs2Hit[g]  = issue_rs2 == REG_SEL_W'(g);
        assign rdHit[g]   = issue_rd == REG_SEL_W'(g);
        assign wbHit[g]   = wb_valid && wb_rd == REG_SEL_W'(g);
        assign killHit[g] = kill_valid && kill_rd == REG_SEL_W'(g);
        // A single outstanding write retiring this cycle is bypassed from
        // the regfile, so it does not block a reader.
        assign busy[g]    = pending[g] && !(wbHit[g] && cnt[g] == CNT_W'(1));
        assign full[g]    = cnt[g] == CNT_MAX;
        assign inc[g]     = rdHit[g] && accept && issue_rd_used;

        reg_pend_counter #(.CNT_W(CNT_W)) uCnt (
            .clk      (clk),
            .rst      (rst),
            .inc      (inc[g]),
            .dec_wb   (wbHit[g]),
            .dec_kill (killHit[g]),
            .count    (cnt[g]),
            .nonzero  (pending[g]),
            .underflow(underflow[g])
        );
    end

    assign stall = issue_valid && ((issue_rs1_used && |(rs1Hit & busy))
                                || (issue_rs2_used && |(rs2Hit & busy))
                                || (issue_rd_used && |(rdHit & full)));
    assign accept = issue_valid && !stall;

    always_ff @(posedge clk)
        err <= rst ? 1'b0 : err | (|underflow);
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed vector table plus randomized run against a reference model
module tb_reg_scoreboard;
    typedef struct packed {
        logic       rst, iv;
        logic [2:0] rs1;
        logic       u1;
        logic [2:0] rs2;
        logic       u2;
        logic [2:0] rd;
        logic       ru, wv;
        logic [2:0] wr;
        logic       kv;
        logic [2:0] kr;
        logic       xStall;
        logic [7:0] xPend;
        logic       xErr;
    } vec_t;

    logic       clk = 0, rst = 1;
    logic       issue_valid = 0, issue_rs1_used = 0, issue_rs2_used = 0, issue_rd_used = 0;
    logic [2:0] issue_rs1 = 0, issue_rs2 = 0, issue_rd = 0, wb_rd = 0, kill_rd = 0;
    logic       wb_valid = 0, kill_valid = 0;
    logic       stall, err;
    logic [7:0] pending;

    int passCnt = 0, totalCnt = 0;
    int mc [8];
    bit me;
    vec_t tbl [$];

    reg_scoreboard dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid),
        .issue_rs1(issue_rs1), .issue_rs1_used(issue_rs1_used),
        .issue_rs2(issue_rs2), .issue_rs2_used(issue_rs2_used),
        .issue_rd(issue_rd), .issue_rd_used(issue_rd_used),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .kill_valid(kill_valid), .kill_rd(kill_rd),
        .stall(stall), .pending(pending), .err(err)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(int r, int iv, int rs1, int u1, int rs2, int u2, int rd, int ru,
                               int wv, int wr, int kv, int kr, int s, int p, int e);
        vec_t t;
        t.rst = r[0]; t.iv = iv[0]; t.rs1 = rs1[2:0]; t.u1 = u1[0];
        t.rs2 = rs2[2:0]; t.u2 = u2[0]; t.rd = rd[2:0]; t.ru = ru[0];
        t.wv = wv[0]; t.wr = wr[2:0]; t.kv = kv[0]; t.kr = kr[2:0];
        t.xStall = s[0]; t.xPend = p[7:0]; t.xErr = e[0];
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        totalCnt++;
        if (act !== exp) $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        else passCnt++;
    endtask

    task automatic drive(input vec_t t);
        rst = t.rst; issue_valid = t.iv;
        issue_rs1 = t.rs1; issue_rs1_used = t.u1;
        issue_rs2 = t.rs2; issue_rs2_used = t.u2;
        issue_rd = t.rd; issue_rd_used = t.ru;
        wb_valid = t.wv; wb_rd = t.wr; kill_valid = t.kv; kill_rd = t.kr;
    endtask

    // Reference model: stall decision from the current counts and this cycle's inputs.
    function automatic bit mStall();
        if (!issue_valid) return 0;
        if (issue_rs1_used && mc[issue_rs1] > 0 && !(wb_valid && wb_rd == issue_rs1 && mc[issue_rs1] == 1)) return 1;
        if (issue_rs2_used && mc[issue_rs2] > 0 && !(wb_valid && wb_rd == issue_rs2 && mc[issue_rs2] == 1)) return 1;
        return issue_rd_used && mc[issue_rd] == 3;
    endfunction

    function automatic logic [7:0] mPend();
        logic [7:0] p = 0;
        for (int i = 0; i < 8; i++) p[i] = mc[i] > 0;
        return p;
    endfunction

    task automatic mUpdate(input bit accept);
        int d [8];
        if (rst) begin
            for (int i = 0; i < 8; i++) mc[i] = 0;
            me = 0;
            return;
        end
        for (int i = 0; i < 8; i++) d[i] = 0;
        if (accept && issue_rd_used) d[issue_rd]++;
        if (wb_valid) d[wb_rd]--;
        if (kill_valid) d[kill_rd]--;
        for (int i = 0; i < 8; i++) begin
            mc[i] += d[i];
            if (mc[i] < 0) begin
                me = 1;
                mc[i] = 0;
            end
        end
    endtask

    function automatic logic [2:0] pickBusy();
        int s = $urandom_range(0, 7);
        if ($urandom_range(0, 9) == 0) return 3'(s);
        for (int k = 0; k < 8; k++) if (mc[(s + k) % 8] > 0) return 3'((s + k) % 8);
        return 3'(s);
    endfunction

    initial begin
        //                 rst iv rs1 u1 rs2 u2 rd ru wv wr kv kr  stall pend  err
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h00, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 'h00, 0));
        tbl.push_back(v(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h08, 0));
        tbl.push_back(v(0, 1, 3, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 'h08, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h00, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 'h00, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 5, 1, 1, 5, 0, 0, 0, 'h20, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 'h20, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 'h00, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 'h04, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 'h04, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 1, 'h04, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 'h04, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 'h04, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 'h04, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h00, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 'h00, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h00, 1));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 'h00, 1));
        tbl.push_back(v(0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h80, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 'h80, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h00, 1));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 'h00, 1));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 'h02, 1));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 'h02, 1));
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0, 'h12, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h00, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 'h00, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 'h01, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 'h01, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h00, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 6, 1, 1, 6, 1, 6, 0, 'h00, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h00, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h00, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h00, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 'h00, 0));
        tbl.push_back(v(0, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 1, 'h10, 0));
        tbl.push_back(v(0, 1, 4, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 'h10, 0));
        tbl.push_back(v(0, 1, 0, 0, 4, 1, 0, 0, 1, 4, 0, 0, 0, 'h10, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h00, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 'h00, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 'h08, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h00, 0));

        rst = 1;
        @(posedge clk);
        @(negedge clk);
        foreach (tbl[i]) begin
            drive(tbl[i]);
            #1;
            chk("vec_stall", i, 8'(stall), 8'(tbl[i].xStall));
            chk("vec_pending", i, pending, tbl[i].xPend);
            chk("vec_err", i, 8'(err), 8'(tbl[i].xErr));
            @(negedge clk);
        end

        rst = 1;
        issue_valid = 0; wb_valid = 0; kill_valid = 0;
        mUpdate(0);
        @(negedge clk);
        for (int c = 0; c < 800; c++) begin
            bit xs;
            rst = $urandom_range(0, 59) == 0;
            issue_valid = $urandom_range(0, 3) != 0;
            issue_rs1 = 3'($urandom_range(0, 7)); issue_rs1_used = 1'($urandom_range(0, 1));
            issue_rs2 = 3'($urandom_range(0, 7)); issue_rs2_used = 1'($urandom_range(0, 1));
            issue_rd = 3'($urandom_range(0, 7)); issue_rd_used = 1'($urandom_range(0, 1));
            wb_valid = $urandom_range(0, 2) == 0; wb_rd = pickBusy();
            kill_valid = $urandom_range(0, 7) == 0; kill_rd = pickBusy();
            #1;
            xs = mStall();
            chk("rnd_stall", c, 8'(stall), 8'(xs));
            chk("rnd_pending", c, pending, mPend());
            chk("rnd_err", c, 8'(err), 8'(me));
            mUpdate(issue_valid && !xs);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
